// File: rtl/sram1024x36_pkg.sv
// Shared geometry, request payload and controller state for the 1024x36 SRAM controller.
package sram1024x36_pkg;

  localparam int unsigned WORD_W = 36;
  localparam int unsigned ADR_W  = 10;
  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 9;
  localparam int unsigned CNT_W  = ADR_W - 1;

  typedef struct packed {
    logic              valid;
    logic              write;
    logic [ADR_W-1:0]  adr;
    logic [WORD_W-1:0] wdata;
    logic [LANES-1:0]  byte_en;
  } sram_req_t;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Expand per-lane byte enables into the macro's active-low bit write enables.
  function automatic logic [WORD_W-1:0] lane_mask(input logic [LANES-1:0] be);
    logic [WORD_W-1:0] m;
    m = '1;
    for (int unsigned i = 0; i < LANES; i++) begin
      m[i*LANE_W +: LANE_W] = {LANE_W{~be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/sram1024x36_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; priority passes to the other requester after each grant.
module rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_req1,
  input  logic i_req2,
  output logic o_gnt1_c,
  output logic o_gnt2_c
);

  logic r_prio2;  // 0: requester 1 preferred, 1: requester 2 preferred

  always_comb begin
    o_gnt1_c = 1'b0;
    o_gnt2_c = 1'b0;
    if (i_en) begin
      if (i_req1 && (!i_req2 || !r_prio2)) begin
        o_gnt1_c = 1'b1;
      end else if (i_req2) begin
        o_gnt2_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio2 <= 1'b0;
    end else if (o_gnt1_c) begin
      r_prio2 <= 1'b1;
    end else if (o_gnt2_c) begin
      r_prio2 <= 1'b0;
    end
  end

endmodule

// File: rtl/sram1024x36_ctrl.sv
// Controller for the 1024x36 two-port SRAM: zero-clear sequencer, port A for R0,
// port B round-robin between R1/R2, collision blocking and one-cycle read responses.
module sram1024x36_ctrl
  import sram1024x36_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              Flush,
  output logic              Busy,

  input  logic              R0Valid,
  output logic              R0Ready,
  input  logic              R0Write,
  input  logic [ADR_W-1:0]  R0Adr,
  input  logic [WORD_W-1:0] R0WData,
  input  logic [LANES-1:0]  R0ByteEn,
  output logic              R0RspValid,
  output logic [WORD_W-1:0] R0RData,

  input  logic              R1Valid,
  output logic              R1Ready,
  input  logic              R1Write,
  input  logic [ADR_W-1:0]  R1Adr,
  input  logic [WORD_W-1:0] R1WData,
  input  logic [LANES-1:0]  R1ByteEn,
  output logic              R1RspValid,
  output logic [WORD_W-1:0] R1RData,

  input  logic              R2Valid,
  output logic              R2Ready,
  input  logic              R2Write,
  input  logic [ADR_W-1:0]  R2Adr,
  input  logic [WORD_W-1:0] R2WData,
  input  logic [LANES-1:0]  R2ByteEn,
  output logic              R2RspValid,
  output logic [WORD_W-1:0] R2RData,

  output logic              CEBA,
  output logic              CEBB,
  output logic              WEBA,
  output logic              WEBB,
  output logic [ADR_W-1:0]  AA,
  output logic [ADR_W-1:0]  AB,
  output logic [WORD_W-1:0] DA,
  output logic [WORD_W-1:0] DB,
  output logic [WORD_W-1:0] BWEBA,
  output logic [WORD_W-1:0] BWEBB,
  input  logic [WORD_W-1:0] QA,
  input  logic [WORD_W-1:0] QB
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic r_rsp0;
  logic r_rspb;
  logic r_own2;

  sram_req_t w_req0, w_req1, w_req2, w_reqb;
  logic      w_run, w_clear;
  logic      w_col1, w_col2, w_elig1, w_elig2;
  logic      w_gnt1, w_gnt2, w_acc0, w_accb;

  assign w_req0 = '{valid: R0Valid, write: R0Write, adr: R0Adr, wdata: R0WData, byte_en: R0ByteEn};
  assign w_req1 = '{valid: R1Valid, write: R1Write, adr: R1Adr, wdata: R1WData, byte_en: R1ByteEn};
  assign w_req2 = '{valid: R2Valid, write: R2Write, adr: R2Adr, wdata: R2WData, byte_en: R2ByteEn};

  assign w_run   = (r_state == RUN) && !reset;
  assign w_clear = (r_state == CLEAR) && !reset;

  // R0 owns port A unconditionally; a port B requester touching the same word must wait.
  assign w_col1  = w_req0.valid && (w_req1.adr == w_req0.adr) && (w_req0.write || w_req1.write);
  assign w_col2  = w_req0.valid && (w_req2.adr == w_req0.adr) && (w_req0.write || w_req2.write);
  assign w_elig1 = w_req1.valid && !w_col1;
  assign w_elig2 = w_req2.valid && !w_col2;

  rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .i_en     (w_run),
    .i_req1   (w_elig1),
    .i_req2   (w_elig2),
    .o_gnt1_c (w_gnt1),
    .o_gnt2_c (w_gnt2)
  );

  assign w_reqb = w_gnt2 ? w_req2 : w_req1;
  assign w_acc0 = w_run && w_req0.valid;
  assign w_accb = (w_gnt1 || w_gnt2) && w_reqb.valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Clear sequencer: one word pair per cycle, Flush restarts from word pair 0.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (r_state == CLEAR) begin
      if (Flush) begin
        w_cnt_nxt = '0;
      end else if (r_cnt == '1) begin
        w_state_nxt = RUN;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt = CNT_W'(r_cnt + 1'b1);
      end
    end else if (Flush) begin
      w_state_nxt = CLEAR;
      w_cnt_nxt   = '0;
    end
  end

  always_comb begin
    CEBA  = 1'b1;
    WEBA  = 1'b1;
    AA    = w_req0.adr;
    DA    = w_req0.wdata;
    BWEBA = '1;
    CEBB  = 1'b1;
    WEBB  = 1'b1;
    AB    = w_reqb.adr;
    DB    = w_reqb.wdata;
    BWEBB = '1;
    if (w_clear) begin
      CEBA  = 1'b0;
      WEBA  = 1'b0;
      AA    = {r_cnt, 1'b0};
      DA    = '0;
      BWEBA = '0;
      CEBB  = 1'b0;
      WEBB  = 1'b0;
      AB    = {r_cnt, 1'b1};
      DB    = '0;
      BWEBB = '0;
    end else begin
      if (w_acc0) begin
        CEBA  = 1'b0;
        WEBA  = ~w_req0.write;
        BWEBA = lane_mask(w_req0.byte_en);
      end
      if (w_accb) begin
        CEBB  = 1'b0;
        WEBB  = ~w_reqb.write;
        BWEBB = lane_mask(w_reqb.byte_en);
      end
    end
  end

  // Read response tracking; the port B owner selects which requester sees QB.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp0 <= 1'b0;
      r_rspb <= 1'b0;
      r_own2 <= 1'b0;
    end else begin
      r_rsp0 <= w_acc0 && !w_req0.write;
      r_rspb <= w_accb && !w_reqb.write;
      r_own2 <= w_gnt2;
    end
  end

  assign Busy       = reset || (r_state == CLEAR);
  assign R0Ready    = w_run;
  assign R1Ready    = w_gnt1;
  assign R2Ready    = w_gnt2;
  assign R0RspValid = r_rsp0 && !reset;
  assign R1RspValid = r_rspb && !r_own2 && !reset;
  assign R2RspValid = r_rspb && r_own2 && !reset;
  assign R0RData    = QA;
  assign R1RData    = QB;
  assign R2RData    = QB;

endmodule

// File: tb/tb_sram1024x36_ctrl.sv
// Directed bench for sram1024x36_ctrl with a behavioural byte-writable two-port SRAM.
module tb_sram1024x36_ctrl;

  logic        clk;
  logic        reset;
  logic        Flush;
  logic        Busy;
  logic        v   [3];
  logic        wr  [3];
  logic [9:0]  adr [3];
  logic [35:0] wd  [3];
  logic [3:0]  be  [3];
  logic        rdy [3];
  logic        rv  [3];
  logic [35:0] rd  [3];
  logic        CEBA, CEBB, WEBA, WEBB;
  logic [9:0]  AA, AB;
  logic [35:0] DA, DB, BWEBA, BWEBB;
  logic [35:0] QA, QB;
  logic [35:0] mem [1024];

  int checks;
  int errors;
  int ncyc;
  bit okstb;

  sram1024x36_ctrl dut (
    .clk(clk), .reset(reset), .Flush(Flush), .Busy(Busy),
    .R0Valid(v[0]), .R0Ready(rdy[0]), .R0Write(wr[0]), .R0Adr(adr[0]), .R0WData(wd[0]),
    .R0ByteEn(be[0]), .R0RspValid(rv[0]), .R0RData(rd[0]),
    .R1Valid(v[1]), .R1Ready(rdy[1]), .R1Write(wr[1]), .R1Adr(adr[1]), .R1WData(wd[1]),
    .R1ByteEn(be[1]), .R1RspValid(rv[1]), .R1RData(rd[1]),
    .R2Valid(v[2]), .R2Ready(rdy[2]), .R2Write(wr[2]), .R2Adr(adr[2]), .R2WData(wd[2]),
    .R2ByteEn(be[2]), .R2RspValid(rv[2]), .R2RData(rd[2]),
    .CEBA(CEBA), .CEBB(CEBB), .WEBA(WEBA), .WEBB(WEBB), .AA(AA), .AB(AB),
    .DA(DA), .DB(DB), .BWEBA(BWEBA), .BWEBB(BWEBB), .QA(QA), .QB(QB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Macro model: nonzero power-up contents so the clear is observable.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 36'h5A5A5A5A5;
  end

  always @(posedge clk) begin
    if (!CEBA) begin
      if (!WEBA) mem[AA] <= (mem[AA] & BWEBA) | (DA & ~BWEBA);
      else       QA <= mem[AA];
    end
    if (!CEBB) begin
      if (!WEBB) mem[AB] <= (mem[AB] & BWEBB) | (DB & ~BWEBB);
      else       QB <= mem[AB];
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk36(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    for (int n = 0; n < 3; n++) v[n] = 1'b0;
    Flush = 1'b0;
  endtask

  task automatic req(input int n, input logic w, input logic [9:0] a,
                     input logic [35:0] d, input logic [3:0] b);
    v[n] = 1'b1; wr[n] = w; adr[n] = a; wd[n] = d; be[n] = b;
  endtask

  task automatic step();
    @(negedge clk);
    idle_all();
  endtask

  // Counts Busy cycles from the current settled point and checks every clear strobe.
  task automatic count_clear(output int n, output bit ok);
    n = 0;
    ok = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (!Busy) break;
      if (CEBA !== 1'b0 || WEBA !== 1'b0 || AA !== 10'(2*n) || DA !== 36'h0 || BWEBA !== 36'h0 ||
          CEBB !== 1'b0 || WEBB !== 1'b0 || AB !== 10'(2*n+1) || DB !== 36'h0 || BWEBB !== 36'h0)
        ok = 1'b0;
      n++;
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nz;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    Flush  = 1'b0;
    for (int n = 0; n < 3; n++) begin
      v[n] = 1'b1; wr[n] = 1'b0; adr[n] = 10'(n); wd[n] = 36'h0; be[n] = 4'hF;
    end

    // Reset: strobes and readies held off even with requests pending.
    repeat (3) @(negedge clk);
    #1;
    chk1("rst_busy", Busy, 1'b1);
    chk1("rst_ceba", CEBA, 1'b1);
    chk1("rst_cebb", CEBB, 1'b1);
    chk1("rst_r0rdy", rdy[0], 1'b0);
    chk1("rst_r1rdy", rdy[1], 1'b0);

    // Initial clear.
    step(); reset = 1'b0; #1;
    count_clear(ncyc, okstb);
    chk36("clr_cycles", 36'(ncyc), 36'd512);
    chk1("clr_strobes", okstb, 1'b1);
    nz = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== 36'h0) nz++;
    chk36("clr_nonzero_words", 36'(nz), 36'd0);
    chk1("run_r0rdy", rdy[0], 1'b1);

    req(0, 1'b0, 10'h3FF, 36'h0, 4'hF); #1;
    chk1("rd_ceba", CEBA, 1'b0);
    chk1("rd_weba", WEBA, 1'b1);
    chk36("rd_aa", 36'(AA), 36'h3FF);
    step(); #1;
    chk1("rd_rspv0", rv[0], 1'b1);
    chk36("rd_rdata0", rd[0], 36'h0);

    // Byte write sequence.
    step(); req(0, 1'b1, 10'h155, 36'h3FF, 4'hF); #1;
    chk1("bw_weba", WEBA, 1'b0);
    chk36("bw_bweba", BWEBA, 36'h0);
    chk36("bw_da", DA, 36'h3FF);
    step(); req(1, 1'b1, 10'h155, 36'h0, 4'b0010); #1;
    chk1("bw_r1rdy", rdy[1], 1'b1);
    chk1("bw_webb", WEBB, 1'b0);
    chk36("bw_ab", 36'(AB), 36'h155);
    chk36("bw_bwebb", BWEBB, 36'hFFFFC01FF);
    step(); req(2, 1'b0, 10'h155, 36'h0, 4'h0); #1;
    chk1("bw_wr_norsp", rv[1], 1'b0);
    chk1("bw_r2rdy", rdy[2], 1'b1);
    step(); #1;
    chk1("bw_rspv2", rv[2], 1'b1);
    chk36("bw_rdata2", rd[2], 36'h0000001FF);

    // Write/read collision at 0x010, then read/read sharing.
    step(); req(0, 1'b1, 10'h010, 36'h123456789, 4'hF); req(1, 1'b0, 10'h010, 36'h0, 4'hF); #1;
    chk1("col_r0rdy", rdy[0], 1'b1);
    chk1("col_r1rdy", rdy[1], 1'b0);
    chk1("col_cebb", CEBB, 1'b1);
    step(); req(1, 1'b0, 10'h010, 36'h0, 4'hF); #1;
    chk1("col_r1rdy_next", rdy[1], 1'b1);
    step(); #1;
    chk1("col_rspv1", rv[1], 1'b1);
    chk36("col_rdata1", rd[1], 36'h123456789);
    step(); req(0, 1'b0, 10'h010, 36'h0, 4'hF); req(1, 1'b0, 10'h010, 36'h0, 4'hF); #1;
    chk1("rr_same_r0rdy", rdy[0], 1'b1);
    chk1("rr_same_r1rdy", rdy[1], 1'b1);
    step(); #1;
    chk1("rr_same_rspv0", rv[0], 1'b1);
    chk36("rr_same_rdata0", rd[0], 36'h123456789);
    chk1("rr_same_rspv1", rv[1], 1'b1);
    chk36("rr_same_rdata1", rd[1], 36'h123456789);

    // Round robin streaming; R1 was granted last so R2 leads.
    step(); req(0, 1'b1, 10'h020, 36'h111111111, 4'hF); #1;
    step(); req(0, 1'b1, 10'h021, 36'h222222222, 4'hF); #1;
    for (int k = 0; k < 4; k++) begin
      step(); req(1, 1'b0, 10'h020, 36'h0, 4'hF); req(2, 1'b0, 10'h021, 36'h0, 4'hF); #1;
      chk1($sformatf("rr%0d_r2rdy", k), rdy[2], (k % 2) == 0);
      chk1($sformatf("rr%0d_r1rdy", k), rdy[1], (k % 2) == 1);
      if (k == 1 || k == 3) begin
        chk1($sformatf("rr%0d_rspv2", k), rv[2], 1'b1);
        chk36($sformatf("rr%0d_rdata2", k), rd[2], 36'h222222222);
      end else if (k == 2) begin
        chk1($sformatf("rr%0d_rspv1", k), rv[1], 1'b1);
        chk36($sformatf("rr%0d_rdata1", k), rd[1], 36'h111111111);
      end
    end
    step(); #1;
    chk1("rr_tail_rspv1", rv[1], 1'b1);
    chk1("rr_tail_rspv2", rv[2], 1'b0);
    chk36("rr_tail_rdata1", rd[1], 36'h111111111);

    // Flush alongside an accepted read.
    step(); req(0, 1'b0, 10'h020, 36'h0, 4'hF); Flush = 1'b1; #1;
    chk1("fl_r0rdy", rdy[0], 1'b1);
    step(); #1;
    chk1("fl_rspv0", rv[0], 1'b1);
    chk36("fl_rdata0", rd[0], 36'h111111111);
    count_clear(ncyc, okstb);
    chk36("fl_clr_cycles", 36'(ncyc), 36'd512);
    chk1("fl_clr_strobes", okstb, 1'b1);
    req(0, 1'b0, 10'h020, 36'h0, 4'hF); #1;
    step(); #1;
    chk1("fl_after_rspv0", rv[0], 1'b1);
    chk36("fl_after_rdata0", rd[0], 36'h0);

    // Reset suppresses a pending response, then reset again mid-clear.
    step(); req(0, 1'b0, 10'h3FF, 36'h0, 4'hF); #1;
    step(); reset = 1'b1; #1;
    chk1("rs_rspv0", rv[0], 1'b0);
    chk1("rs_busy", Busy, 1'b1);
    step(); reset = 1'b0; #1;
    repeat (200) begin
      @(negedge clk);
      #1;
    end
    chk36("rs_cnt200_aa", 36'(AA), 36'h190);
    reset = 1'b1; #1;
    chk1("rs_mid_ceba", CEBA, 1'b1);
    chk1("rs_mid_cebb", CEBB, 1'b1);
    step(); reset = 1'b0; #1;
    count_clear(ncyc, okstb);
    chk36("rs_clr_cycles", 36'(ncyc), 36'd512);
    chk1("rs_clr_strobes", okstb, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram1024x36_ctrl.md
# sram1024x36_ctrl

Controller and arbiter for the 1024x36 two-port byte-writable SRAM macro used in the cache and tag arrays. After reset or on `Flush`, it zero-initialises all 1024 entries. Port A is dedicated to requester 0, the high-priority core-side path. Port B is shared round-robin between requesters 1 (refill) and 2 (snoop). The block also drives the SRAM's active-low strobes, detects same-address port collisions, and returns read data with a one-cycle response.

## Interface
Parameters:
- None. Geometry is fixed: 1024 words, 36 bits per word, four 9-bit byte lanes.

Ports (n = 0,1,2):
- `clk`  in  1  the single clock; SRAM `CLKA`/`CLKB` are tied to it externally.
- `reset`  in  1  synchronous, active-high.
- `Flush`  in  1  request a full zero-clear of the array.
- `Busy`  out  1  high while clearing.
- `RnValid`  in  1  request valid.
- `RnReady`  out  1  request accepted this cycle when `RnValid & RnReady`.
- `RnWrite`  in  1  1 = write, 0 = read.
- `RnAdr`  in  10  word address.
- `RnWData`  in  36  write data.
- `RnByteEn`  in  4  lane i covers bits [9i+8:9i].
- `RnRspValid`  out  1  read data valid.
- `RnRData`  out  36  read data.
- `CEBA`, `CEBB`  out  1  active-low chip enable.
- `WEBA`, `WEBB`  out  1  active-low write enable.
- `AA`, `AB`  out  10  address.
- `DA`, `DB`  out  36  write data.
- `BWEBA`, `BWEBB`  out  36  active-low bit write enables.
- `QA`, `QB`  in  36  SRAM read data, valid the cycle after the strobe.

## Operation
State machine, states CLEAR and RUN:
- **Reset:** state goes to CLEAR, the 9-bit clear counter `Cnt` goes to 0, and `Prio` goes to R1.
- **CLEAR, each cycle:**
  - Port A writes address {Cnt,0} and port B writes address {Cnt,1}.
  - D = 0, BWEB = all 0, CEB = WEB = 0.
  - `Cnt` increments; at `Cnt` = 511 the state moves to RUN.
  - `Flush` during CLEAR restarts `Cnt` at 0.
- **RUN:** `Flush` moves to CLEAR with `Cnt` = 0 on the next cycle. Requests accepted in the `Flush` cycle complete normally, including their read responses.
- **Ready:**
  - All `RnReady` are 0 in CLEAR.
  - In RUN, `R0Ready` = 1.
  - `R1Ready` / `R2Ready` per the port B arbitration below.
- **Port B arbitration:**
  - Requester n ∈ {1,2} is eligible when it is valid and does not collide.
  - A collision exists when `R0Valid` is high, `RnAdr` equals `R0Adr`, and `R0Write` or `RnWrite` is set.
  - One eligible requester: it is granted.
  - Two eligible requesters: `Prio` wins.
  - `Prio` flips to the other requester only on a grant.
  - R0 always wins a collision.
- **Strobe mapping:**
  - Accepted request: CEB = 0, WEB = ~Write, A = Adr, D = WData, BWEB lane i = {9{~ByteEn[i]}}.
  - No accepted request: CEB = 1, WEB = 1, BWEB = all 1.
  - A write with `ByteEn` = 0 is still issued; no bits change.
- **Responses:**
  - A read accepted in cycle t gives `RnRspValid` = 1 in cycle t+1, with `RnRData` taken from `QA` (n = 0) or `QB` (port B owner registered in cycle t).
  - Writes produce no response.
  - There is no response backpressure.

## Timing
- Request acceptance and SRAM strobes occur in the same cycle, combinational from inputs and registered state. Read latency is 1 cycle.
- `RnReady` is combinational on `R0Valid/R0Adr/R0Write` and the requester's own inputs. It does not depend on the requester's own `Valid` beyond eligibility.
- While `reset` is high:
  - `CEBA` = `CEBB` = 1, all `RnReady` = 0, all `RnRspValid` = 0.
  - `Busy` = 1; the first clear write occurs in the first cycle after `reset` deasserts.
- A full clear takes 512 cycles. `Busy` falls and `RnReady` rises in the cycle after the write to addresses 1022/1023.
- `reset` during CLEAR restarts the clear at 0. `reset` in the cycle after an accepted read suppresses that read's `RspValid`.
- `RData` outside `RspValid` is don't-care.

## Structure
- Shared package `sram1024x36_pkg`:
  - Constants: word width, address width, lane count, lane width.
  - `sram_req_t` struct: Valid, Write, Adr, WData, ByteEn.
  - State enum {CLEAR, RUN}.
- Sub-module `rr_arb2`: two-requester round-robin arbiter with the `Prio` register, update on grant.
- Everything else lives in the top: clear FSM/counter, collision compare, strobe muxing, response registers (valid bits plus port B owner).
- Estimated size: 180–250 lines.

## Test plan
- **Reset and clear:** reset, then hold idle.
  - `Busy` is 1 for exactly 512 cycles.
  - Each SRAM port writes 512 distinct addresses with D = 0.
  - A subsequent R0 read of 0x3FF returns 0 one cycle later.
- **Byte write:**
  - R0 writes 0x3FF to address 0x155 with `ByteEn` = 4'b1111.
  - R1 then writes 0 to 0x155 with `ByteEn` = 4'b0010; `BWEBB` = 36'hFFFF_C01FF.
  - An R2 read of 0x155 returns 0x3FF & ~(0x1FF<<9) = 0x1FF, i.e. 36'h0000001FF.
- **Collision:**
  - R0 writes and R1 reads, both at address 0x010, in the same cycle.
  - `R1Ready` = 0 that cycle and R1 is granted the next cycle.
  - Read/read at the same address: both are granted.
- **Round robin:** R1 and R2 stream reads continuously; grants alternate R1, R2, R1…, and each `RspValid` carries the correct port B data.
- **Flush mid-stream:** assert `Flush` together with an accepted R0 read of a nonzero word.
  - The read response arrives next cycle with the old data.
  - `Busy` is then high for 512 cycles.
  - Afterwards the word reads 0.
- **Reset mid-clear:** assert `reset` at `Cnt` = 200; the clear restarts from 0 and runs a full 512 cycles.
